// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and defaults for the pipeline stall controller.
package spu_pkg;

    localparam int unsigned MEM_TIMEOUT_DEF  = 255;
    localparam int unsigned DRAIN_CYCLES_DEF = 3;
    localparam int unsigned STALL_CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HALTED  = 2'd3
    } state_e;

    // One cycle's worth of pipeline-register control.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic exmem_write;
        logic memwb_write;
        logic ifid_flush;
        logic idex_bubble;
    } ctrl_t;

    // Free-running pipeline.
    localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_write: 1'b1, exmem_write: 1'b1,
                                   memwb_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
    // Hold the front end, let older instructions retire, bubble into EX.
    localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, exmem_write: 1'b1,
                                     memwb_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b1};
    // Redirect fetch and squash the two wrong-path instructions.
    localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, ifid_write: 1'b1, exmem_write: 1'b1,
                                      memwb_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};
    // Whole pipeline frozen.
    localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, exmem_write: 1'b0,
                                      memwb_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b0};
    // Frozen with the front-end registers forced to NOPs.
    localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0, exmem_write: 1'b0,
                                     memwb_write: 1'b0, ifid_flush: 1'b1, idex_bubble: 1'b1};

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard requests in, pipeline control and status out.
interface pipeline_stall_controller_if;
    import spu_pkg::*;

    logic                   Stall;
    logic                   MemBusy;
    logic                   BranchTaken_EX;
    logic                   Halt_ID;
    logic                   PCWrite;
    logic                   IFIDWrite;
    logic                   EXMEMWrite;
    logic                   MEMWBWrite;
    logic                   IFIDFlush;
    logic                   IDEXBubble;
    logic                   MemError;
    logic                   Halted;
    logic [STALL_CNT_W-1:0] StallCycles;

    // Side that raises hazard requests and consumes the controls.
    modport master (
        output Stall, MemBusy, BranchTaken_EX, Halt_ID,
        input  PCWrite, IFIDWrite, EXMEMWrite, MEMWBWrite,
        input  IFIDFlush, IDEXBubble, MemError, Halted, StallCycles
    );

    // The controller itself.
    modport slave (
        input  Stall, MemBusy, BranchTaken_EX, Halt_ID,
        output PCWrite, IFIDWrite, EXMEMWrite, MEMWBWrite,
        output IFIDFlush, IDEXBubble, MemError, Halted, StallCycles
    );

endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Up-counter that sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count increments until the maximum value is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush/halt sequencing for a five-stage in-order core.
module pipeline_stall_controller
    import spu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                        Clock,
    input  logic                        Reset_n,
    pipeline_stall_controller_if.slave  bus
);

    localparam int unsigned WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_e              r_state;
    logic                r_branch_pending;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [DRAIN_W-1:0]  r_drain_cnt;
    logic                r_mem_error;

    state_e              w_state_nx;
    logic                w_pending_nx;
    logic [WAIT_W-1:0]   w_wait_nx;
    logic [DRAIN_W-1:0]  w_drain_nx;
    logic                w_error_nx;
    logic                w_branch;
    ctrl_t               w_ctrl;
    ctrl_t               w_out;
    logic                w_stall_inc;

    // State and bookkeeping registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state          <= ST_RUN;
            r_branch_pending <= 1'b0;
            r_wait_cnt       <= '0;
            r_drain_cnt      <= '0;
            r_mem_error      <= 1'b0;
        end else begin
            r_state          <= w_state_nx;
            r_branch_pending <= w_pending_nx;
            r_wait_cnt       <= w_wait_nx;
            r_drain_cnt      <= w_drain_nx;
            r_mem_error      <= w_error_nx;
        end
    end

    // Next state and combinational pipeline controls.
    always_comb begin
        w_state_nx   = r_state;
        w_pending_nx = r_branch_pending;
        w_wait_nx    = r_wait_cnt;
        w_drain_nx   = r_drain_cnt;
        w_error_nx   = r_mem_error;
        w_ctrl       = CTRL_RUN;
        w_branch     = bus.BranchTaken_EX | r_branch_pending;

        // Consecutive-busy watchdog, active in every live state.
        if (r_state != ST_HALTED) begin
            if (!bus.MemBusy) begin
                w_wait_nx = '0;
            end else if (!r_mem_error) begin
                w_wait_nx = r_wait_cnt + WAIT_W'(1);
                if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    w_error_nx = 1'b1;
                end
            end
        end

        case (r_state)
            ST_RUN, ST_MEMWAIT: begin
                if (r_mem_error) begin
                    w_ctrl     = CTRL_FREEZE;
                    w_state_nx = ST_HALTED;
                end else if (bus.MemBusy) begin
                    // Branch cannot redirect while frozen; remember it.
                    w_ctrl     = CTRL_FREEZE;
                    w_state_nx = ST_MEMWAIT;
                    if (bus.BranchTaken_EX) begin
                        w_pending_nx = 1'b1;
                    end
                end else if (w_branch) begin
                    w_ctrl       = CTRL_BRANCH;
                    w_pending_nx = 1'b0;
                    w_state_nx   = ST_RUN;
                end else if (bus.Halt_ID) begin
                    // Halt moves on to EX this cycle; younger work is bubbled.
                    w_ctrl     = CTRL_RUN;
                    w_drain_nx = '0;
                    w_state_nx = (DRAIN_CYCLES == 0) ? ST_HALTED : ST_DRAIN;
                end else if (bus.Stall) begin
                    w_ctrl     = CTRL_STALL;
                    w_state_nx = ST_RUN;
                end else begin
                    w_ctrl     = CTRL_RUN;
                    w_state_nx = ST_RUN;
                end
            end

            ST_DRAIN: begin
                if (r_mem_error) begin
                    w_ctrl     = CTRL_FREEZE;
                    w_state_nx = ST_HALTED;
                end else if (bus.MemBusy) begin
                    // Drain progress is held, not restarted.
                    w_ctrl = CTRL_FREEZE;
                end else begin
                    w_ctrl = CTRL_STALL;
                    if (r_drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                        w_state_nx = ST_HALTED;
                    end else begin
                        w_drain_nx = r_drain_cnt + DRAIN_W'(1);
                    end
                end
            end

            ST_HALTED: begin
                w_ctrl = CTRL_FREEZE;
            end

            default: begin
                w_ctrl     = CTRL_FREEZE;
                w_state_nx = ST_HALTED;
            end
        endcase

        w_out = Reset_n ? w_ctrl : CTRL_RESET;
    end

    assign w_stall_inc = ~w_out.pc_write & (r_state != ST_HALTED);

    assign bus.PCWrite    = w_out.pc_write;
    assign bus.IFIDWrite  = w_out.ifid_write;
    assign bus.EXMEMWrite = w_out.exmem_write;
    assign bus.MEMWBWrite = w_out.memwb_write;
    assign bus.IFIDFlush  = w_out.ifid_flush;
    assign bus.IDEXBubble = w_out.idex_bubble;
    assign bus.MemError   = r_mem_error;
    assign bus.Halted     = (r_state == ST_HALTED);

    // Front-end stall cycle statistic.
    sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk     (Clock),
        .rst_n   (Reset_n),
        .i_inc   (w_stall_inc),
        .o_count (bus.StallCycles)
    );

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: maximum consecutive MemBusy cycles tolerated.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 3: bubble cycles inserted after a halt before freezing.
REQ-003 SHALL have port Clock, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port Stall, input, 1: load-use hazard request from the ID-stage hazard detector.
REQ-006 SHALL have port MemBusy, input, 1: data memory not ready this cycle.
REQ-007 SHALL have port BranchTaken_EX, input, 1: taken branch or jump resolved in EX.
REQ-008 SHALL have port Halt_ID, input, 1: halt instruction decoded in ID.
REQ-009 SHALL have ports PCWrite, IFIDWrite, EXMEMWrite, MEMWBWrite, all output, 1: pipeline register write enables.
REQ-010 SHALL have ports IFIDFlush and IDEXBubble, both output, 1: squash IF/ID and insert NOP into ID/EX.
REQ-011 SHALL have port MemError, output, 1: sticky memory-timeout flag.
REQ-012 SHALL have port Halted, output, 1: pipeline permanently frozen.
REQ-013 SHALL have port StallCycles, output, 16: saturating count of front-end stall cycles.

Function
REQ-014 SHALL implement the states RUN, MEMWAIT, DRAIN and HALTED; all control outputs SHALL be combinational from the state and the current inputs.
REQ-015 In RUN with no requests, SHALL drive all Write outputs to 1 and IFIDFlush=IDEXBubble=0.
REQ-016 Priority within a cycle SHALL be MemBusy > BranchTaken_EX > Halt_ID > Stall.
REQ-017 On Stall alone in RUN, SHALL drive PCWrite=IFIDWrite=0 and IDEXBubble=1, with EXMEMWrite=MEMWBWrite=1, for every cycle Stall is high.
REQ-018 On BranchTaken_EX in RUN, SHALL drive PCWrite=1, IFIDFlush=1 and IDEXBubble=1 in the same cycle; any simultaneous Stall or Halt_ID SHALL be ignored.
REQ-019 On MemBusy, SHALL drive all four Write outputs to 0 and IFIDFlush=IDEXBubble=0, and SHALL enter MEMWAIT; MEMWAIT SHALL persist while MemBusy=1.
REQ-020 A BranchTaken_EX seen while MemBusy=1 SHALL set BranchPending; on the first cycle with MemBusy=0, the branch response of REQ-018 SHALL be applied, BranchPending SHALL clear, and the state SHALL return to RUN.
REQ-021 The wait counter SHALL count consecutive MemBusy cycles; when the count reaches MEM_TIMEOUT, MemError SHALL be set and the state SHALL go to HALTED on the next edge.
REQ-022 On Halt_ID in RUN (no branch or MemBusy), SHALL enter DRAIN.
REQ-023 In DRAIN, SHALL drive PCWrite=IFIDWrite=0, IDEXBubble=1 and EX/MEM/WB writes=1 for exactly DRAIN_CYCLES cycles, then enter HALTED.
REQ-024 MemBusy during DRAIN SHALL freeze as REQ-019 and suspend, but not reset, the drain count.
REQ-025 In HALTED, SHALL drive all Write outputs to 0 and Halted=1; HALTED SHALL be left only by reset.
REQ-026 StallCycles SHALL increment on each cycle with PCWrite=0 outside HALTED and SHALL saturate at 16'hFFFF.

Reset
REQ-027 While Reset_n=0, SHALL force state=RUN, BranchPending=0, counters=0, MemError=0 and StallCycles=0.
REQ-028 While Reset_n=0, SHALL drive all Write outputs to 0, IDEXBubble=1, IFIDFlush=1 and Halted=0.
REQ-029 Reset assertion mid-MEMWAIT or mid-DRAIN SHALL abandon the operation with no residual pending state.

Structure
REQ-030 The state enum and the MEM_TIMEOUT and DRAIN_CYCLES defaults SHALL reside in shared package spu_pkg.
REQ-031 StallCycles SHALL be a sub-module instance sat_counter with a width parameter; no other sub-modules.

Verification
REQ-032 Stall=1 for 1 cycle in RUN -> PCWrite=0, IFIDWrite=0, IDEXBubble=1, EXMEMWrite=1 that cycle; StallCycles 0->1.
REQ-033 Stall=1 with BranchTaken_EX=1 -> PCWrite=1, IFIDFlush=1, IDEXBubble=1; StallCycles unchanged.
REQ-034 MemBusy high for 4 cycles with BranchTaken_EX pulsed on cycle 2 -> all writes 0 for 4 cycles; cycle 5: IFIDFlush=1, PCWrite=1.
REQ-035 MemBusy held 300 cycles with MEM_TIMEOUT=255 -> MemError=1 after 255 cycles; Halted=1 next cycle; both remain until Reset_n=0.
REQ-036 Halt_ID pulse -> 3 cycles IDEXBubble=1 with PCWrite=0, then Halted=1 and all writes 0; Reset_n low in the 2nd drain cycle -> RUN outputs after release.
REQ-037 Force 70000 stall cycles -> StallCycles holds 16'hFFFF.
